// File: rtl/mem_port_arbiter.sv
// Age-ordered lock arbiter for NUM_SICS memory requesters sharing one data memory.
// One owner at a time; reads are combinational, writes land at the edge that ends a granted cycle.
module mem_port_arbiter #(
    parameter int NUM_SICS  = 4,
    parameter int ID_WIDTH  = 6,
    parameter int MEM_WORDS = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_SICS-1:0]                req,
    input  logic [NUM_SICS-1:0][ID_WIDTH-1:0]  req_issue_id,
    input  logic [NUM_SICS-1:0]                release_lock,
    input  logic [NUM_SICS-1:0][29:0]          addr,
    input  logic [NUM_SICS-1:0][31:0]          wdata,
    input  logic [NUM_SICS-1:0]                wen,
    input  logic [ID_WIDTH-1:0]                head_id,
    output logic [NUM_SICS-1:0]                grant,
    output logic [31:0]                        rdata
);

    localparam int OW = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [OW-1:0]       owner_r;
    logic [OW-1:0]       owner_nxt_s;
    logic [OW-1:0]       winner_s;
    logic [ID_WIDTH-1:0] best_age_s;
    logic                found_s;
    logic                owner_req_s;
    logic                granted_s;
    logic                in_range_s;
    logic                mem_we_s;
    logic [29:0]         owner_addr_s;
    logic [31:0]         mem_r [MEM_WORDS];

    // Distance from the oldest in-flight instruction; modular so issue ids may wrap.
    function automatic logic [ID_WIDTH-1:0] age_of(input logic [ID_WIDTH-1:0] id,
                                                   input logic [ID_WIDTH-1:0] head);
        return id - head;
    endfunction

    // Oldest requester wins; strict compare keeps the lowest index on equal ages.
    always_comb begin
        winner_s   = '0;
        best_age_s = '0;
        found_s    = 1'b0;
        for (int i = 0; i < NUM_SICS; i++) begin
            if (req[i] && (!found_s || (age_of(req_issue_id[i], head_id) < best_age_s))) begin
                winner_s   = OW'(i);
                best_age_s = age_of(req_issue_id[i], head_id);
                found_s    = 1'b1;
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Owner-side view of the shared port: grant, range check, read data and write strobe.
    always_comb begin
        owner_req_s  = req[owner_r];
        granted_s    = (state_r == LOCKED) && owner_req_s;
        owner_addr_s = addr[owner_r];
        in_range_s   = (owner_addr_s < 30'(MEM_WORDS));
        mem_we_s     = granted_s && wen[owner_r] && in_range_s && rst_n;
        grant        = '0;
        if (granted_s) begin
            grant[owner_r] = 1'b1;
        end else begin
            grant = '0;
        end
        if (granted_s && in_range_s) begin
            rdata = mem_r[owner_addr_s[AW-1:0]];
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    // Next-state: lock on any request, unlock on owner abort or owner release.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_nxt_s = LOCKED;
                    owner_nxt_s = winner_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCKED: begin
                if (!owner_req_s || release_lock[owner_r]) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                owner_nxt_s = '0;
            end
        endcase
    end

    // State and owner registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            owner_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            owner_r <= owner_nxt_s;
        end
    end

    // Data memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[owner_addr_s[AW-1:0]] <= wdata[owner_r];
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: expected grants/read data are queued at drive time
// and popped when a grant appears; a reference memory tracks every store the bench issues.
module tb_mem_port_arbiter;

    localparam int N   = 4;
    localparam int IDW = 6;
    localparam int MW  = 1024;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          req;
    logic [N-1:0][IDW-1:0] req_issue_id;
    logic [N-1:0]          release_lock;
    logic [N-1:0][29:0]    addr;
    logic [N-1:0][31:0]    wdata;
    logic [N-1:0]          wen;
    logic [IDW-1:0]        head_id;
    logic [N-1:0]          grant;
    logic [31:0]           rdata;

    typedef struct {
        logic [N-1:0] g;
        logic [31:0]  rd;
        bit           chk_rd;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_mem [int];
    int          checks = 0;
    int          errors = 0;

    mem_port_arbiter #(.NUM_SICS(N), .ID_WIDTH(IDW), .MEM_WORDS(MW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_issue_id(req_issue_id),
        .release_lock(release_lock), .addr(addr), .wdata(wdata), .wen(wen),
        .head_id(head_id), .grant(grant), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [N-1:0] g, input logic [31:0] rd, input bit chk);
        exp_t e;
        e.g = g; e.rd = rd; e.chk_rd = chk;
        sb_q.push_back(e);
    endtask

    task automatic wait_grant(input int budget, output logic [N-1:0] g, output logic [31:0] rd,
                              output int cyc, output bit to);
        g = '0; rd = '0; cyc = 0; to = 1'b1;
        for (int c = 1; c <= budget && to; c++) begin
            @(negedge clk);
            if (grant !== 4'b0000) begin
                g = grant; rd = rdata; cyc = c; to = 1'b0;
            end
        end
    endtask

    // One release-with-grant access from IDLE, starting just after a rising edge.
    task automatic run_single(input int sic, input logic [29:0] a, input logic we,
                              input logic [31:0] wd, output logic [N-1:0] g, output logic [31:0] rd,
                              output int cyc, output bit to, output logic [N-1:0] g2,
                              output logic [31:0] rd2);
        req[sic] = 1'b1; addr[sic] = a; wen[sic] = we; wdata[sic] = wd; release_lock[sic] = 1'b1;
        wait_grant(8, g, rd, cyc, to);
        @(negedge clk);
        g2 = grant; rd2 = rdata;
        req[sic] = 1'b0; wen[sic] = 1'b0; release_lock[sic] = 1'b0;
        @(posedge clk); #1;
        if (!to && we && (a < 30'(MW))) ref_mem[int'(a)] = wd;
    endtask

    task automatic test_reset();
        logic [N-1:0] g; logic [31:0] rd; int cyc; bit to; exp_t e;
        req = 4'b1111; release_lock = 4'b0000;
        repeat (2) @(negedge clk);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        rst_n = 1'b1; req = 4'b0001; addr[0] = 30'd0; release_lock[0] = 1'b1;
        push_exp(4'b0001, 32'h0, 1'b0);
        wait_grant(8, g, rd, cyc, to);
        e = sb_q.pop_front();
        checks++; if (to || g !== e.g) begin errors++; $display("FAIL first_arb got %b want %b to=%0d", g, e.g, to); end
        checks++; if (cyc != 1) begin errors++; $display("FAIL first_arb_latency got %0d want 1", cyc); end
        @(posedge clk); #1;
        req = 4'b0000; release_lock = 4'b0000;
    endtask

    task automatic test_store();
        logic [N-1:0] g, g2; logic [31:0] rd, rd2; int cyc; bit to; exp_t e;
        push_exp(4'b0010, 32'h0, 1'b0);
        run_single(1, 30'd5, 1'b1, 32'hDEAD_BEEF, g, rd, cyc, to, g2, rd2);
        e = sb_q.pop_front();
        checks++; if (to || g !== e.g) begin errors++; $display("FAIL store_grant got %b want %b", g, e.g); end
        checks++; if (cyc != 2) begin errors++; $display("FAIL store_latency got %0d want 2", cyc); end
        checks++; if (g2 !== 4'b0000) begin errors++; $display("FAIL store_idle got %b want 0000", g2); end
    endtask

    task automatic test_load();
        logic [N-1:0] g, g2; logic [31:0] rd, rd2; int cyc; bit to; exp_t e;
        push_exp(4'b0100, ref_mem[5], 1'b1);
        run_single(2, 30'd5, 1'b0, 32'h0, g, rd, cyc, to, g2, rd2);
        e = sb_q.pop_front();
        checks++; if (to || g !== e.g) begin errors++; $display("FAIL load_grant got %b want %b", g, e.g); end
        checks++; if (rd !== e.rd) begin errors++; $display("FAIL load_rdata got %h want %h", rd, e.rd); end
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL load_rdata_idle got %h want 0", rd2); end
    endtask

    task automatic test_age_wrap();
        logic [N-1:0] g; logic [31:0] rd; int cyc; bit to; exp_t e;
        head_id = 6'd62;
        req_issue_id[0] = 6'd1; req_issue_id[3] = 6'd63; req_issue_id[1] = 6'd62;
        addr[0] = 30'd5; addr[3] = 30'd5; release_lock = 4'b1001;
        push_exp(4'b1000, ref_mem[5], 1'b1);
        push_exp(4'b0001, ref_mem[5], 1'b1);
        req = 4'b1001;
        wait_grant(8, g, rd, cyc, to);
        e = sb_q.pop_front();
        checks++; if (to || g !== e.g) begin errors++; $display("FAIL age_first got %b want %b", g, e.g); end
        checks++; if (rd !== e.rd) begin errors++; $display("FAIL age_first_rdata got %h want %h", rd, e.rd); end
        @(posedge clk); #1;
        req[3] = 1'b0; release_lock[3] = 1'b0;
        wait_grant(8, g, rd, cyc, to);
        e = sb_q.pop_front();
        checks++; if (to || g !== e.g) begin errors++; $display("FAIL age_second got %b want %b", g, e.g); end
        @(posedge clk); #1;
        req = 4'b0000; release_lock = 4'b0000;
    endtask

    task automatic test_abort();
        logic [N-1:0] g, g2; logic [31:0] rd, rd2; int cyc; bit to; exp_t e;
        push_exp(4'b0001, 32'h0, 1'b0);
        run_single(0, 30'd7, 1'b1, 32'hA5A5_A5A5, g, rd, cyc, to, g2, rd2);
        e = sb_q.pop_front();
        checks++; if (to || g !== e.g) begin errors++; $display("FAIL abort_prestore got %b want %b", g, e.g); end
        head_id = 6'd0; req_issue_id[0] = 6'd0; req_issue_id[1] = 6'd5;
        addr[0] = 30'd7; wen[0] = 1'b1; wdata[0] = 32'h1111_1111;
        addr[1] = 30'd7; wen[1] = 1'b0; release_lock = 4'b0011;
        push_exp(4'b0010, ref_mem[7], 1'b1);
        req = 4'b0011;
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL abort_grant got %b want 0000", grant); end
        wait_grant(8, g, rd, cyc, to);
        e = sb_q.pop_front();
        checks++; if (to || g !== e.g) begin errors++; $display("FAIL abort_next got %b want %b", g, e.g); end
        checks++; if (rd !== e.rd) begin errors++; $display("FAIL abort_mem got %h want %h", rd, e.rd); end
        @(posedge clk); #1;
        req = 4'b0000; wen = 4'b0000; release_lock = 4'b0000;
    endtask

    task automatic test_out_of_range();
        logic [N-1:0] g, g2; logic [31:0] rd, rd2; int cyc; bit to; exp_t e;
        push_exp(4'b0001, 32'h0, 1'b0);
        run_single(0, 30'd0, 1'b1, 32'hCAFE_F00D, g, rd, cyc, to, g2, rd2);
        e = sb_q.pop_front();
        push_exp(4'b0100, 32'h0, 1'b1);
        run_single(2, 30'(MW), 1'b1, 32'h1234_5678, g, rd, cyc, to, g2, rd2);
        e = sb_q.pop_front();
        checks++; if (to || g !== e.g) begin errors++; $display("FAIL oor_grant got %b want %b", g, e.g); end
        checks++; if (rd !== e.rd) begin errors++; $display("FAIL oor_rdata got %h want %h", rd, e.rd); end
        push_exp(4'b0010, ref_mem[0], 1'b1);
        run_single(1, 30'd0, 1'b0, 32'h0, g, rd, cyc, to, g2, rd2);
        e = sb_q.pop_front();
        checks++; if (rd !== e.rd) begin errors++; $display("FAIL oor_nowrite got %h want %h", rd, e.rd); end
    endtask

    task automatic test_hold_release();
        logic [N-1:0] g, g2; logic [31:0] rd, rd2; int cyc; bit to; exp_t e;
        head_id = 6'd0; req_issue_id[1] = 6'd4; addr[1] = 30'd5; wen[1] = 1'b0;
        req_issue_id[0] = 6'd0; addr[0] = 30'd5; wen[0] = 1'b1; wdata[0] = 32'h5555_5555;
        release_lock = 4'b0001;
        push_exp(4'b0010, ref_mem[5], 1'b1);
        req = 4'b0010;
        wait_grant(8, g, rd, cyc, to);
        e = sb_q.pop_front();
        checks++; if (to || g !== e.g) begin errors++; $display("FAIL hold_grant got %b want %b", g, e.g); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (grant !== e.g || rdata !== e.rd) begin
                errors++; $display("FAIL hold_cycle%0d got %b/%h want %b/%h", k, grant, rdata, e.g, e.rd);
            end
        end
        release_lock[1] = 1'b1;
        @(posedge clk); #1;
        req = 4'b0000; wen = 4'b0000; release_lock = 4'b0000;
        push_exp(4'b1000, ref_mem[5], 1'b1);
        run_single(3, 30'd5, 1'b0, 32'h0, g, rd, cyc, to, g2, rd2);
        e = sb_q.pop_front();
        checks++; if (rd !== e.rd) begin errors++; $display("FAIL nonowner_wen got %h want %h", rd, e.rd); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] g, g2; logic [31:0] rd, rd2; int cyc; bit to; exp_t e; int sic;
        head_id = 6'd10;
        req_issue_id[0] = 6'd12; req_issue_id[1] = 6'd11; req_issue_id[2] = 6'd11; req_issue_id[3] = 6'd10;
        for (int i = 0; i < N; i++) begin
            addr[i] = 30'(10 + i); wdata[i] = 32'h1000_0000 + 32'(i);
        end
        wen = 4'b1111; release_lock = 4'b1111;
        push_exp(4'b1000, 32'h0, 1'b0); push_exp(4'b0010, 32'h0, 1'b0);
        push_exp(4'b0100, 32'h0, 1'b0); push_exp(4'b0001, 32'h0, 1'b0);
        req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            wait_grant(8, g, rd, cyc, to);
            e = sb_q.pop_front();
            checks++; if (to || g !== e.g) begin errors++; $display("FAIL b2b_order%0d got %b want %b", k, g, e.g); end
            checks++; if (cyc != 2) begin errors++; $display("FAIL b2b_spacing%0d got %0d want 2", k, cyc); end
            sic = 0;
            for (int i = 0; i < N; i++) if (e.g[i]) sic = i;
            @(posedge clk); #1;
            req[sic] = 1'b0; wen[sic] = 1'b0; release_lock[sic] = 1'b0;
            ref_mem[10 + sic] = 32'h1000_0000 + 32'(sic);
        end
        for (int i = 0; i < N; i++) begin
            push_exp(4'b0001, ref_mem[10 + i], 1'b1);
            run_single(0, 30'(10 + i), 1'b0, 32'h0, g, rd, cyc, to, g2, rd2);
            e = sb_q.pop_front();
            checks++; if (rd !== e.rd) begin errors++; $display("FAIL b2b_data%0d got %h want %h", i, rd, e.rd); end
        end
    endtask

    task automatic test_reset_mid_lock();
        logic [N-1:0] g, g2; logic [31:0] rd, rd2; int cyc; bit to; exp_t e;
        push_exp(4'b1000, 32'h0, 1'b0);
        run_single(3, 30'd20, 1'b1, 32'h0BAD_F00D, g, rd, cyc, to, g2, rd2);
        e = sb_q.pop_front();
        addr[3] = 30'd20; wen[3] = 1'b1; wdata[3] = 32'hFFFF_FFFF; release_lock[3] = 1'b0;
        push_exp(4'b1000, ref_mem[20], 1'b1);
        req[3] = 1'b1;
        wait_grant(8, g, rd, cyc, to);
        e = sb_q.pop_front();
        checks++; if (to || g !== e.g) begin errors++; $display("FAIL rml_grant got %b want %b", g, e.g); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rml_grant_drop got %b want 0000", grant); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rml_rdata got %h want 0", rdata); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; req = 4'b0000; wen = 4'b0000;
        @(posedge clk); #1;
        push_exp(4'b0001, ref_mem[20], 1'b1);
        run_single(0, 30'd20, 1'b0, 32'h0, g, rd, cyc, to, g2, rd2);
        e = sb_q.pop_front();
        checks++; if (rd !== e.rd) begin errors++; $display("FAIL rml_nowrite got %h want %h", rd, e.rd); end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_issue_id = '0; release_lock = '0;
        addr = '0; wdata = '0; wen = '0; head_id = '0;
        test_reset();
        test_store();
        test_load();
        test_age_wrap();
        test_abort();
        test_out_of_range();
        test_hold_release();
        test_back_to_back();
        test_reset_mid_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
